// File: rtl/noc_packet_injector.sv
// NoC packet injector: turns packet requests and payload words into head/body/tail
// flits for one router input channel, gated by a credit counter of downstream buffer space.
module noc_packet_injector #(
    parameter int BUFFER_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  router_address,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [0:3]  pkt_dest,
    input  logic [0:3]  pkt_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [0:63] data_in,
    output logic [0:67] channel_out,
    input  logic [0:1]  flow_ctrl_in,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    localparam logic [3:0] FULL_CREDITS = 4'(BUFFER_DEPTH);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_credits;
    logic [0:3]  r_dest;
    logic [0:3]  r_src;
    logic [0:3]  r_len;
    logic [3:0]  r_wordCount;
    logic [0:67] r_channel;
    logic        r_error;

    logic        w_accept;
    logic        w_sendHead;
    logic        w_sendBody;
    logic        w_send;
    logic        w_isTail;
    logic        w_haveCredit;
    logic        w_creditRet;
    logic        w_unused;
    logic [0:67] w_flit;

    assign w_creditRet  = flow_ctrl_in[0];
    assign w_unused     = flow_ctrl_in[1];
    assign w_haveCredit = (r_credits != 4'd0);
    assign w_accept     = pkt_valid && pkt_ready;
    assign w_send       = w_sendHead || w_sendBody;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // pkt_ready is gated by the reset input so it stays low while reset is held.
    always_comb begin
        w_nextState = r_state;
        pkt_ready   = 1'b0;
        data_ready  = 1'b0;
        w_sendHead  = 1'b0;
        w_sendBody  = 1'b0;
        w_isTail    = 1'b0;
        case (r_state)
            IDLE: begin
                pkt_ready = reset;
                if (pkt_valid && reset) begin
                    w_nextState = HEAD;
                end
            end
            HEAD: begin
                if (w_haveCredit) begin
                    w_sendHead  = 1'b1;
                    w_nextState = (r_len == 4'd0) ? IDLE : BODY;
                end
            end
            BODY: begin
                data_ready = w_haveCredit;
                if (w_haveCredit && data_valid) begin
                    w_sendBody = 1'b1;
                    w_isTail   = (r_wordCount == (r_len - 4'd1));
                    if (w_isTail) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_flit = '0;
        if (w_sendHead) begin
            w_flit[0]     = 1'b1;
            w_flit[1]     = 1'b1;
            w_flit[2]     = (r_len == 4'd0);
            w_flit[3:6]   = r_dest;
            w_flit[7:10]  = r_src;
            w_flit[11:14] = r_len;
        end else if (w_sendBody) begin
            w_flit[0]    = 1'b1;
            w_flit[2]    = w_isTail;
            w_flit[3:66] = data_in;
        end
    end

    // A send and a return in the same cycle cancel; a return at full credit is an overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits <= FULL_CREDITS;
            r_error   <= 1'b0;
        end else if (w_send && !w_creditRet) begin
            r_credits <= r_credits - 4'd1;
        end else if (!w_send && w_creditRet) begin
            if (r_credits == FULL_CREDITS) begin
                r_error <= 1'b1;
            end else begin
                r_credits <= r_credits + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dest      <= '0;
            r_src       <= '0;
            r_len       <= '0;
            r_wordCount <= '0;
            r_channel   <= '0;
        end else begin
            r_channel <= w_flit;
            if (w_accept) begin
                r_dest      <= pkt_dest;
                r_src       <= router_address;
                r_len       <= pkt_len;
                r_wordCount <= '0;
            end else if (w_sendBody) begin
                r_wordCount <= r_wordCount + 4'd1;
            end
        end
    end

    assign channel_out = r_channel;
    assign error       = r_error;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_noc_packet_injector.sv
// Testbench for noc_packet_injector: directed scenarios plus a randomized run whose
// expected flit stream is precomputed per packet and whose credit use is tracked by count.
module tb_noc_packet_injector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  router_address;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [0:3]  pkt_dest;
    logic [0:3]  pkt_len;
    logic        data_valid;
    logic        data_ready;
    logic [0:63] data_in;
    logic [0:67] channel_out;
    logic [0:1]  flow_ctrl_in;
    logic        error;
    logic        busy;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    noc_packet_injector #(.BUFFER_DEPTH(DEPTH)) u_dut (
        .clk(clk),
        .reset(reset),
        .router_address(router_address),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_dest(pkt_dest),
        .pkt_len(pkt_len),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_in(data_in),
        .channel_out(channel_out),
        .flow_ctrl_in(flow_ctrl_in),
        .error(error),
        .busy(busy)
    );

    function automatic logic [0:67] headFlit(input logic [3:0] dest, input logic [3:0] src,
                                             input logic [3:0] len);
        logic [0:67] f;
        f        = '0;
        f[0]     = 1'b1;
        f[1]     = 1'b1;
        f[2]     = (len == 4'd0);
        f[3:6]   = dest;
        f[7:10]  = src;
        f[11:14] = len;
        return f;
    endfunction

    function automatic logic [0:67] bodyFlit(input logic [63:0] d, input logic tail);
        logic [0:67] f;
        f       = '0;
        f[0]    = 1'b1;
        f[2]    = tail;
        f[3:66] = d;
        return f;
    endfunction

    function automatic logic [63:0] randWord();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset          = 1'b0;
        pkt_valid      = 1'b0;
        data_valid     = 1'b0;
        flow_ctrl_in   = 2'b00;
        pkt_dest       = '0;
        pkt_len        = '0;
        data_in        = '0;
        router_address = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Holds a packet request until accepted; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] dest, input logic [3:0] len,
                                 input logic [3:0] src);
        bit done;
        done           = 1'b0;
        router_address = src;
        pkt_dest       = dest;
        pkt_len        = len;
        pkt_valid      = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (pkt_ready === 1'b1) done = 1'b1;
            tick();
        end
        pkt_valid = 1'b0;
        checkCount++;
        if (!done) $display("[TB] FAIL accept: pkt_ready got 0 want 1 within 20 cycles");
        else passCount++;
    endtask

    task automatic countFlits(input int cycles, output int n, output logic [0:67] first);
        n     = 0;
        first = '0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (channel_out !== '0) begin
                if (n == 0) first = channel_out;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        pkt_valid      = 1'b1;
        data_valid     = 1'b1;
        flow_ctrl_in   = 2'b00;
        pkt_dest       = 4'd5;
        pkt_len        = 4'd2;
        data_in        = '1;
        router_address = 4'd1;
        #3;
        checkCount++;
        if (channel_out !== '0) $display("[TB] FAIL rstChannel: got %h want 0", channel_out);
        else passCount++;
        checkCount++;
        if ({error, busy, pkt_ready, data_ready} !== 4'b0000)
            $display("[TB] FAIL rstOutputs: got %b want 0000", {error, busy, pkt_ready, data_ready});
        else passCount++;
        tick();
        tick();
        checkCount++;
        if ({busy, pkt_ready, channel_out[0]} !== 3'b000)
            $display("[TB] FAIL rstHeld: got %b want 000", {busy, pkt_ready, channel_out[0]});
        else passCount++;
        reset      = 1'b1;
        pkt_valid  = 1'b0;
        data_valid = 1'b0;
        tick();
        checkCount++;
        if ({pkt_ready, busy} !== 2'b10)
            $display("[TB] FAIL rstRelease: got %b want 10", {pkt_ready, busy});
        else passCount++;
    endtask

    task automatic test_single_head();
        applyReset();
        applyStimulus(4'd9, 4'd0, 4'd3);
        checkCount++;
        if ({channel_out !== '0, busy} !== 2'b01)
            $display("[TB] FAIL headCycle: got ch=%h busy=%b want ch=0 busy=1", channel_out, busy);
        else passCount++;
        tick();
        checkCount++;
        if (channel_out !== headFlit(4'd9, 4'd3, 4'd0))
            $display("[TB] FAIL singleHead: got %h want %h", channel_out, headFlit(4'd9, 4'd3, 4'd0));
        else passCount++;
        checkCount++;
        if ({pkt_ready, busy} !== 2'b10)
            $display("[TB] FAIL singleIdle: got %b want 10", {pkt_ready, busy});
        else passCount++;
        tick();
        checkCount++;
        if (channel_out !== '0) $display("[TB] FAIL singleGap: got %h want 0", channel_out);
        else passCount++;
    endtask

    task automatic test_payload();
        logic [63:0] w[3];
        logic [3:0]  dest;
        logic [3:0]  src;
        int          n;
        logic [0:67] first;
        applyReset();
        for (int i = 0; i < 3; i++) w[i] = randWord();
        dest       = 4'($urandom_range(0, 15));
        src        = 4'($urandom_range(0, 15));
        data_valid = 1'b1;
        data_in    = w[0];
        applyStimulus(dest, 4'd3, src);
        checkCount++;
        if (data_ready !== 1'b0) $display("[TB] FAIL headDataReady: got %b want 0", data_ready);
        else passCount++;
        tick();
        checkCount++;
        if (channel_out !== headFlit(dest, src, 4'd3))
            $display("[TB] FAIL payloadHead: got %h want %h", channel_out, headFlit(dest, src, 4'd3));
        else passCount++;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkCount++;
            if (channel_out !== bodyFlit(w[k], k == 2))
                $display("[TB] FAIL payloadBody%0d: got %h want %h", k, channel_out, bodyFlit(w[k], k == 2));
            else passCount++;
            if (k < 2) data_in = w[k + 1];
        end
        checkCount++;
        if ({busy, pkt_ready} !== 2'b01)
            $display("[TB] FAIL payloadDone: got %b want 01", {busy, pkt_ready});
        else passCount++;
        applyStimulus(dest, 4'd0, src);
        countFlits(4, n, first);
        checkCount++;
        if (n != 0 || busy !== 1'b1)
            $display("[TB] FAIL zeroCredit: got flits=%0d busy=%b want flits=0 busy=1", n, busy);
        else passCount++;
        flow_ctrl_in = 2'b10;
        tick();
        flow_ctrl_in = 2'b00;
        checkCount++;
        if (channel_out !== '0) $display("[TB] FAIL pulseEarly: got %h want 0", channel_out);
        else passCount++;
        tick();
        checkCount++;
        if (channel_out !== headFlit(dest, src, 4'd0))
            $display("[TB] FAIL pulseHead: got %h want %h", channel_out, headFlit(dest, src, 4'd0));
        else passCount++;
    endtask

    task automatic test_stall();
        logic [63:0] w[6];
        int          n;
        logic [0:67] first;
        applyReset();
        for (int i = 0; i < 6; i++) w[i] = randWord();
        data_valid = 1'b1;
        data_in    = w[0];
        applyStimulus(4'd6, 4'd6, 4'd2);
        tick();
        checkCount++;
        if (channel_out !== headFlit(4'd6, 4'd2, 4'd6))
            $display("[TB] FAIL stallHead: got %h want %h", channel_out, headFlit(4'd6, 4'd2, 4'd6));
        else passCount++;
        for (int k = 0; k < DEPTH - 1; k++) begin
            tick();
            checkCount++;
            if (channel_out !== bodyFlit(w[k], 1'b0))
                $display("[TB] FAIL stallBody%0d: got %h want %h", k, channel_out, bodyFlit(w[k], 1'b0));
            else passCount++;
            data_in = w[k + 1];
        end
        checkCount++;
        if (data_ready !== 1'b0) $display("[TB] FAIL stallReady: got %b want 0", data_ready);
        else passCount++;
        countFlits(3, n, first);
        checkCount++;
        if (n != 0 || busy !== 1'b1 || data_ready !== 1'b0)
            $display("[TB] FAIL stallHold: got flits=%0d busy=%b ready=%b want 0 1 0", n, busy, data_ready);
        else passCount++;
        flow_ctrl_in = 2'b10;
        tick();
        flow_ctrl_in = 2'b00;
        checkCount++;
        if (channel_out !== '0 || data_ready !== 1'b1)
            $display("[TB] FAIL stallPulse: got ch=%h ready=%b want ch=0 ready=1", channel_out, data_ready);
        else passCount++;
        tick();
        checkCount++;
        if (channel_out !== bodyFlit(w[3], 1'b0))
            $display("[TB] FAIL stallResume: got %h want %h", channel_out, bodyFlit(w[3], 1'b0));
        else passCount++;
        data_in = w[4];
        countFlits(3, n, first);
        checkCount++;
        if (n != 0 || data_ready !== 1'b0)
            $display("[TB] FAIL stallAgain: got flits=%0d ready=%b want 0 0", n, data_ready);
        else passCount++;
    endtask

    task automatic test_credit_same_cycle();
        int          n;
        logic [0:67] first;
        applyReset();
        data_valid = 1'b1;
        data_in    = randWord();
        applyStimulus(4'd1, 4'd2, 4'd7);
        countFlits(4, n, first);
        checkCount++;
        if (n != 3) $display("[TB] FAIL sameSetup: got flits=%0d want 3", n);
        else passCount++;
        applyStimulus(4'd12, 4'd0, 4'd7);
        flow_ctrl_in = 2'b10;
        tick();
        flow_ctrl_in = 2'b00;
        checkCount++;
        if (channel_out !== headFlit(4'd12, 4'd7, 4'd0))
            $display("[TB] FAIL sameHead: got %h want %h", channel_out, headFlit(4'd12, 4'd7, 4'd0));
        else passCount++;
        applyStimulus(4'd3, 4'd1, 4'd7);
        countFlits(5, n, first);
        checkCount++;
        if (n != 1 || busy !== 1'b1)
            $display("[TB] FAIL sameCredits: got flits=%0d busy=%b want 1 1", n, busy);
        else passCount++;
        checkCount++;
        if (error !== 1'b0) $display("[TB] FAIL sameError: got %b want 0", error);
        else passCount++;
    endtask

    task automatic test_error();
        int          n;
        logic [0:67] first;
        applyReset();
        flow_ctrl_in = 2'b10;
        tick();
        flow_ctrl_in = 2'b00;
        checkCount++;
        if (error !== 1'b1) $display("[TB] FAIL errorSet: got %b want 1", error);
        else passCount++;
        repeat (3) tick();
        checkCount++;
        if (error !== 1'b1) $display("[TB] FAIL errorSticky: got %b want 1", error);
        else passCount++;
        data_valid = 1'b1;
        data_in    = randWord();
        applyStimulus(4'd2, 4'(DEPTH), 4'd4);
        countFlits(10, n, first);
        checkCount++;
        if (n != DEPTH || busy !== 1'b1)
            $display("[TB] FAIL errorSaturate: got flits=%0d busy=%b want %0d 1", n, busy, DEPTH);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int          n;
        logic [0:67] first;
        applyReset();
        data_valid = 1'b1;
        data_in    = randWord();
        applyStimulus(4'd8, 4'd5, 4'd1);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        checkCount++;
        if (channel_out !== '0 || busy !== 1'b0 || pkt_ready !== 1'b0)
            $display("[TB] FAIL midReset: got ch=%h busy=%b rdy=%b want 0 0 0", channel_out, busy, pkt_ready);
        else passCount++;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        data_valid = 1'b0;
        countFlits(3, n, first);
        checkCount++;
        if (n != 0) $display("[TB] FAIL midNoTail: got flits=%0d want 0", n);
        else passCount++;
        data_valid = 1'b1;
        applyStimulus(4'd10, 4'(DEPTH), 4'd11);
        countFlits(10, n, first);
        checkCount++;
        if (first !== headFlit(4'd10, 4'd11, 4'(DEPTH)))
            $display("[TB] FAIL midHead: got %h want %h", first, headFlit(4'd10, 4'd11, 4'(DEPTH)));
        else passCount++;
        checkCount++;
        if (n != DEPTH) $display("[TB] FAIL midCredits: got flits=%0d want %0d", n, DEPTH);
        else passCount++;
    endtask

    task automatic test_random();
        localparam int N = 20;
        logic [3:0]  pDest[N];
        logic [3:0]  pSrc[N];
        logic [3:0]  pLen[N];
        logic [0:67] expQ[$];
        logic [63:0] wordQ[$];
        logic [63:0] w;
        int          pIdx;
        int          outstanding;
        int          cyc;
        bit          accepted;
        bit          consumed;
        bit          ret;
        applyReset();
        for (int p = 0; p < N; p++) begin
            pDest[p] = 4'($urandom_range(0, 15));
            pSrc[p]  = 4'($urandom_range(0, 15));
            pLen[p]  = 4'($urandom_range(0, 6));
            expQ.push_back(headFlit(pDest[p], pSrc[p], pLen[p]));
            for (int k = 0; k < int'(pLen[p]); k++) begin
                w = randWord();
                wordQ.push_back(w);
                expQ.push_back(bodyFlit(w, k == int'(pLen[p]) - 1));
            end
        end
        pIdx        = 0;
        outstanding = 0;
        cyc         = 0;
        while (expQ.size() > 0 && cyc < 3000) begin
            if (pIdx < N) begin
                if (!pkt_valid) pkt_valid = ($urandom_range(0, 1) == 1);
                pkt_dest       = pDest[pIdx];
                pkt_len        = pLen[pIdx];
                router_address = pSrc[pIdx];
            end else begin
                pkt_valid = 1'b0;
            end
            data_valid   = (wordQ.size() > 0) && ($urandom_range(0, 9) < 7);
            data_in      = (wordQ.size() > 0) ? wordQ[0] : randWord();
            ret          = (outstanding > 0) && ($urandom_range(0, 9) < 4);
            flow_ctrl_in = {ret, 1'($urandom_range(0, 1))};
            accepted     = pkt_valid && pkt_ready;
            consumed     = data_valid && data_ready;
            tick();
            cyc++;
            if (accepted) begin
                pIdx++;
                pkt_valid = 1'b0;
            end
            if (consumed) void'(wordQ.pop_front());
            if (ret) outstanding--;
            if (channel_out !== '0) begin
                outstanding++;
                checkCount++;
                if (outstanding > DEPTH)
                    $display("[TB] FAIL randCredit: got outstanding=%0d want <=%0d", outstanding, DEPTH);
                else if (channel_out !== expQ[0])
                    $display("[TB] FAIL randFlit: got %h want %h", channel_out, expQ[0]);
                else passCount++;
                void'(expQ.pop_front());
            end
        end
        flow_ctrl_in = 2'b00;
        data_valid   = 1'b0;
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL randDrain: got %0d flits left want 0", expQ.size());
        else passCount++;
        tick();
        checkCount++;
        if ({busy, error} !== 2'b00) $display("[TB] FAIL randEnd: got %b want 00", {busy, error});
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_single_head();
        test_payload();
        test_stall();
        test_credit_same_cycle();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
